ahblite_busmatrix_arbiter_ram_rr: RTL and testbench

Output-stage arbiter for the shared on-chip SRAM slave port of the AHB-Lite bus matrix. Grants the port to one of three input stages (DCODE, SYSTEM, DMA) with round-robin fairness. Keeps the grant for the full length of fixed-length bursts and bounded undefined-length bursts. All state advances only on HREADY of the SRAM output stage, so the address-phase mux select never changes mid-transfer.

---
 rtl/ahblite_busmatrix_arbiter_ram_rr.sv | 151 +++++++++++++++
 tb/tb_ahblite_busmatrix_arbiter_ram_rr.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ahblite_busmatrix_arbiter_ram_rr.sv
// Round-robin arbiter for the shared SRAM output stage of the AHB-Lite bus matrix (DCODE, SYSTEM, DMA).
// Latency: grant registered, visible the cycle after the HREADY edge that decided it; no input-to-output path.
// Backpressure: every register holds while HREADY_Outputstage_RAM is low; optional lock hold via ARB_RAM_LOCK_EN.
module ahblite_busmatrix_arbiter_ram_rr #(
    parameter int unsigned MAX_INCR_BEATS = 16
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       REQ_DCODE,
    input  logic       REQ_SYSTEM,
    input  logic       REQ_DMA,
    input  logic       HREADY_Outputstage_RAM,
    input  logic       HSEL_Outputstage_RAM,
    input  logic [1:0] HTRANS_Outputstage_RAM,
    input  logic [2:0] HBURST_Outputstage_RAM,
`ifdef ARB_RAM_LOCK_EN
    input  logic       HMASTLOCK_Outputstage_RAM,
`endif
    output logic [1:0] PORT_SEL_ARBITER_RAM,
    output logic       PORT_NOSEL_ARBITER_RAM
);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_BUSY   = 2'b01;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [1:0] PORT_NONE   = 2'b00;
    localparam logic [1:0] PORT_DCODE  = 2'b01;
    localparam logic [1:0] PORT_SYSTEM = 2'b10;
    localparam logic [1:0] PORT_DMA    = 2'b11;

    localparam logic [7:0] INCR_INIT = 8'(MAX_INCR_BEATS - 1);

    typedef enum logic [1:0] {
        ST_ARB   = 2'b00,
        ST_FIXED = 2'b01,
        ST_INCR  = 2'b10
    } state_t;

    state_t     state;
    logic [7:0] beat_cnt;
    logic [1:0] last_grant;
    logic [1:0] selport;
    logic       noport;

    logic       any_req;
    logic [1:0] winner;
    logic [1:0] arb_sel;
    logic       arb_noport;
    logic       burst_fixed;
    logic       burst_incr;
    logic [7:0] burst_init;
    logic       hold_lock;

    // Round-robin search starting at the port after the last grant
    always_comb begin
        any_req = REQ_DCODE | REQ_SYSTEM | REQ_DMA;
        winner  = PORT_NONE;
        case (last_grant)
            PORT_DCODE: begin
                if (REQ_SYSTEM)     winner = PORT_SYSTEM;
                else if (REQ_DMA)   winner = PORT_DMA;
                else if (REQ_DCODE) winner = PORT_DCODE;
            end
            PORT_SYSTEM: begin
                if (REQ_DMA)         winner = PORT_DMA;
                else if (REQ_DCODE)  winner = PORT_DCODE;
                else if (REQ_SYSTEM) winner = PORT_SYSTEM;
            end
            default: begin
                if (REQ_DCODE)       winner = PORT_DCODE;
                else if (REQ_SYSTEM) winner = PORT_SYSTEM;
                else if (REQ_DMA)    winner = PORT_DMA;
            end
        endcase
        // With nobody requesting, keep the port "selected" only while the slave is addressed
        arb_sel    = any_req ? winner : PORT_NONE;
        arb_noport = any_req ? 1'b0 : ~HSEL_Outputstage_RAM;
    end

    // Decode burst type of the current address phase into the beat budget to hold the grant for
    always_comb begin
        burst_fixed = 1'b0;
        burst_incr  = 1'b0;
        burst_init  = 8'd0;
        case (HBURST_Outputstage_RAM)
            3'b001:         begin burst_incr  = 1'b1; burst_init = INCR_INIT; end
            3'b010, 3'b011: begin burst_fixed = 1'b1; burst_init = 8'd3;      end
            3'b100, 3'b101: begin burst_fixed = 1'b1; burst_init = 8'd7;      end
            3'b110, 3'b111: begin burst_fixed = 1'b1; burst_init = 8'd15;     end
            default: ;
        endcase
    end

`ifdef ARB_RAM_LOCK_EN
    assign hold_lock = HMASTLOCK_Outputstage_RAM;
`else
    assign hold_lock = 1'b0;
`endif

    // Arbitration FSM: advances only on HREADY, holds grant through bursts and locked sequences
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= ST_ARB;
            beat_cnt   <= 8'd0;
            last_grant <= PORT_DMA;
            selport    <= PORT_NONE;
            noport     <= 1'b1;
        end else if (HREADY_Outputstage_RAM && !hold_lock) begin
            case (state)
                ST_ARB: begin
                    if (!noport && HTRANS_Outputstage_RAM == TR_NONSEQ && burst_fixed) begin
                        beat_cnt <= burst_init;
                        state    <= ST_FIXED;
                    end else if (!noport && HTRANS_Outputstage_RAM == TR_NONSEQ && burst_incr) begin
                        beat_cnt <= burst_init;
                        state    <= ST_INCR;
                    end else begin
                        selport <= arb_sel;
                        noport  <= arb_noport;
                        if (any_req) last_grant <= winner;
                    end
                end
                ST_FIXED, ST_INCR: begin
                    if (HTRANS_Outputstage_RAM == TR_SEQ && beat_cnt > 8'd1) begin
                        beat_cnt <= beat_cnt - 8'd1;
                    end else if (HTRANS_Outputstage_RAM != TR_BUSY) begin
                        // Last beat, budget exhausted, or early termination by IDLE/NONSEQ
                        beat_cnt <= 8'd0;
                        state    <= ST_ARB;
                        selport  <= arb_sel;
                        noport   <= arb_noport;
                        if (any_req) last_grant <= winner;
                    end
                end
                default: begin
                    state <= ST_ARB;
                end
            endcase
        end
    end

    assign PORT_SEL_ARBITER_RAM   = selport;
    assign PORT_NOSEL_ARBITER_RAM = noport;

    // TR_IDLE is implied by the fall-through arms above; reference it to document the encoding
    logic unused_idle;
    assign unused_idle = (HTRANS_Outputstage_RAM == TR_IDLE);

endmodule

// File: tb/tb_ahblite_busmatrix_arbiter_ram_rr.sv
// Directed bench for the SRAM round-robin arbiter: reset, rotation, burst hold, termination, async reset.
// Inputs driven 1ns after the rising edge; outputs checked at that same point, after the grant register settles.
// Lock behaviour is exercised only when ARB_RAM_LOCK_EN is defined.
module tb_ahblite_busmatrix_arbiter_ram_rr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_dcode, req_system, req_dma;
    logic       hready, hsel;
    logic [1:0] htrans;
    logic [2:0] hburst;
`ifdef ARB_RAM_LOCK_EN
    logic       hmastlock;
`endif
    logic [1:0] port_sel;
    logic       port_nosel;

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ahblite_busmatrix_arbiter_ram_rr #(.MAX_INCR_BEATS(16)) dut (
        .HCLK                      (clk),
        .HRESETn                   (rst_n),
        .REQ_DCODE                 (req_dcode),
        .REQ_SYSTEM                (req_system),
        .REQ_DMA                   (req_dma),
        .HREADY_Outputstage_RAM    (hready),
        .HSEL_Outputstage_RAM      (hsel),
        .HTRANS_Outputstage_RAM    (htrans),
        .HBURST_Outputstage_RAM    (hburst),
`ifdef ARB_RAM_LOCK_EN
        .HMASTLOCK_Outputstage_RAM (hmastlock),
`endif
        .PORT_SEL_ARBITER_RAM      (port_sel),
        .PORT_NOSEL_ARBITER_RAM    (port_nosel)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic d, input logic s, input logic m);
        req_dcode  = d;
        req_system = s;
        req_dma    = m;
    endtask

    initial begin
        logic [1:0] rr_exp [5];
        rr_exp[0] = 2'b11; rr_exp[1] = 2'b01; rr_exp[2] = 2'b10;
        rr_exp[3] = 2'b11; rr_exp[4] = 2'b01;

        rst_n  = 1'b0;
        set_req(1'b0, 1'b0, 1'b0);
        hready = 1'b1;
        hsel   = 1'b0;
        htrans = 2'b00;
        hburst = 3'b000;
`ifdef ARB_RAM_LOCK_EN
        hmastlock = 1'b0;
`endif
        step();
        step();
        chk("reset_sel", 32'(port_sel), 32'h0);
        chk("reset_nosel", 32'(port_nosel), 32'h1);
        rst_n = 1'b1;

        // idle after reset, nothing requested, slave not addressed
        step();
        chk("idle_sel", 32'(port_sel), 32'h0);
        chk("idle_nosel", 32'(port_nosel), 32'h1);

        // request during a wait state must not be seen
        req_system = 1'b1;
        hready     = 1'b0;
        step();
        chk("wait_no_grant", 32'(port_sel), 32'h0);
        hready = 1'b1;
        step();
        chk("first_grant_sel", 32'(port_sel), 32'h2);
        chk("first_grant_nosel", 32'(port_nosel), 32'h0);

        // all three requesting, SINGLE transfers: rotation continues from SYSTEM
        set_req(1'b1, 1'b1, 1'b1);
        hsel   = 1'b1;
        htrans = 2'b10;
        hburst = 3'b000;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("rr_%0d", i), 32'(port_sel), 32'(rr_exp[i]));
        end

        // DCODE INCR8 with DMA waiting; two wait states on beat 3; DCODE drops its request mid-burst
        set_req(1'b1, 1'b0, 1'b1);
        htrans = 2'b10;
        hburst = 3'b101;
        step();
        chk("incr8_nonseq", 32'(port_sel), 32'h1);
        htrans = 2'b11;
        for (int i = 1; i <= 7; i++) begin
            if (i == 2) begin
                hready = 1'b0;
                step();
                chk("incr8_wait_a", 32'(port_sel), 32'h1);
                step();
                chk("incr8_wait_b", 32'(port_sel), 32'h1);
                hready = 1'b1;
            end
            if (i == 4) req_dcode = 1'b0;
            step();
            chk($sformatf("incr8_seq_%0d", i), 32'(port_sel), (i == 7) ? 32'h3 : 32'h1);
        end

        // SYSTEM INCR4 cut short by IDLE after two beats, DCODE waiting
        set_req(1'b0, 1'b1, 1'b0);
        htrans = 2'b00;
        step();
        chk("sys_grant", 32'(port_sel), 32'h2);
        set_req(1'b1, 1'b1, 1'b0);
        htrans = 2'b10;
        hburst = 3'b011;
        step();
        chk("incr4_nonseq", 32'(port_sel), 32'h2);
        htrans = 2'b11;
        step();
        chk("incr4_seq", 32'(port_sel), 32'h2);
        htrans = 2'b00;
        step();
        chk("incr4_idle_term", 32'(port_sel), 32'h1);
        chk("incr4_idle_nosel", 32'(port_nosel), 32'h0);

        // undefined-length INCR by DCODE, DMA waiting; one BUSY does not consume budget
        set_req(1'b1, 1'b0, 1'b1);
        htrans = 2'b10;
        hburst = 3'b001;
        step();
        chk("incr_nonseq", 32'(port_sel), 32'h1);
        for (int k = 2; k <= 16; k++) begin
            if (k == 5) begin
                htrans = 2'b01;
                step();
                chk("incr_busy", 32'(port_sel), 32'h1);
            end
            htrans = 2'b11;
            step();
            chk($sformatf("incr_phase_%0d", k), 32'(port_sel), (k == 16) ? 32'h3 : 32'h1);
        end

        // no requesters: noport follows HSEL
        set_req(1'b0, 1'b0, 1'b0);
        htrans = 2'b00;
        hsel   = 1'b1;
        step();
        chk("noreq_hsel_sel", 32'(port_sel), 32'h0);
        chk("noreq_hsel_nosel", 32'(port_nosel), 32'h0);
        hsel = 1'b0;
        step();
        chk("noreq_nohsel_nosel", 32'(port_nosel), 32'h1);

        // async reset in the middle of a DCODE INCR16
        hsel      = 1'b1;
        req_dcode = 1'b1;
        step();
        chk("inc16_grant", 32'(port_sel), 32'h1);
        htrans = 2'b10;
        hburst = 3'b111;
        step();
        htrans = 2'b11;
        for (int i = 0; i < 3; i++) step();
        chk("inc16_mid", 32'(port_sel), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_sel", 32'(port_sel), 32'h0);
        chk("async_rst_nosel", 32'(port_nosel), 32'h1);
        set_req(1'b1, 1'b1, 1'b0);
        htrans = 2'b00;
        step();
        chk("rst_held_sel", 32'(port_sel), 32'h0);
        rst_n = 1'b1;
        step();
        chk("post_rst_dcode_first", 32'(port_sel), 32'h1);
        step();
        chk("post_rst_then_sys", 32'(port_sel), 32'h2);

`ifdef ARB_RAM_LOCK_EN
        // locked SINGLE transfers keep SYSTEM granted despite other requesters
        set_req(1'b1, 1'b1, 1'b1);
        hmastlock = 1'b1;
        htrans    = 2'b10;
        hburst    = 3'b000;
        step();
        chk("lock_hold_a", 32'(port_sel), 32'h2);
        step();
        chk("lock_hold_b", 32'(port_sel), 32'h2);
        hmastlock = 1'b0;
        step();
        chk("lock_release", 32'(port_sel), 32'h3);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
